// File: rtl/branch_target_buffer_pkg.sv
// Shared sizing, entry layout and way identifiers for the branch target buffer.
package branch_target_buffer_pkg;

    localparam int N        = 4;
    localparam int ADDR_W   = 32;
    localparam int BTB_SETS = 32;
    localparam int TAG_BITS = 10;
    localparam int IDX_BITS = $clog2(BTB_SETS);

    // Highest PC bit that takes part in the stored partial tag
    localparam int TAG_HI   = TAG_BITS + IDX_BITS + 1;

    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [IDX_BITS-1:0] idx_t;
    typedef logic [TAG_BITS-1:0] tag_t;

    typedef struct packed {
        logic  valid;
        tag_t  tag;
        addr_t target;
    } BTB_ENTRY;

    typedef struct packed {
        logic [BTB_SETS-1:0] way0_valid;
        logic [BTB_SETS-1:0] way1_valid;
        logic [BTB_SETS-1:0] lru;
    } BTB_DEBUG;

    typedef enum logic {
        WAY0 = 1'b0,
        WAY1 = 1'b1
    } way_e;

endpackage

// File: rtl/branch_target_buffer_way.sv
// One way of the BTB: entry array with N combinational read ports, a single
// probe port for the update path and one registered write port.
module btb_way
    import branch_target_buffer_pkg::*;
(
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N-1:0][IDX_BITS-1:0]   rd_idx_i,
    input  logic [N-1:0][TAG_BITS-1:0]   rd_tag_i,
    output logic [N-1:0]                 rd_hit_o,
    output logic [N-1:0][ADDR_W-1:0]     rd_target_o,
    input  logic [IDX_BITS-1:0]          probe_idx_i,
    input  logic [TAG_BITS-1:0]          probe_tag_i,
    output logic                         probe_hit_o,
    output logic                         probe_valid_o,
    input  logic                         we_i,
    input  logic [IDX_BITS-1:0]          wr_idx_i,
    input  logic [TAG_BITS-1:0]          wr_tag_i,
    input  logic [ADDR_W-1:0]            wr_target_i
`ifdef DEBUG
    ,
    output logic [BTB_SETS-1:0]          dbg_valid_o
`endif
);

    BTB_ENTRY entry_q [BTB_SETS];

    // Fetch-side lookups: read the indexed entry and compare its partial tag
    always_comb begin
        for (int i = 0; i < N; i++) begin
            rd_hit_o[i]    = entry_q[rd_idx_i[i]].valid && (entry_q[rd_idx_i[i]].tag == rd_tag_i[i]);
            rd_target_o[i] = entry_q[rd_idx_i[i]].target;
        end
    end

    // Update-side probe so the top level can choose between refresh, fill and evict
    always_comb begin
        probe_valid_o = entry_q[probe_idx_i].valid;
        probe_hit_o   = entry_q[probe_idx_i].valid && (entry_q[probe_idx_i].tag == probe_tag_i);
    end

    // Clear every entry on reset, otherwise write the selected entry when enabled
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < BTB_SETS; s++) begin
                entry_q[s] <= '0;
            end
        end else if (we_i) begin
            entry_q[wr_idx_i] <= '{valid: 1'b1, tag: wr_tag_i, target: wr_target_i};
        end
    end

`ifdef DEBUG
    // Expose the valid column for debug visibility
    always_comb begin
        for (int s = 0; s < BTB_SETS; s++) begin
            dbg_valid_o[s] = entry_q[s].valid;
        end
    end
`endif

endmodule

// File: rtl/branch_target_buffer.sv
// Two-way set-associative branch target buffer: zero-latency N-slot lookup for
// fetch, allocation/refresh from resolved taken branches, one LRU bit per set.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N-1:0][ADDR_W-1:0]   fetch_PCs,
    input  logic [N-1:0]               fetch_valid,
    output logic [N-1:0]               btb_hits,
    output logic [N-1:0][ADDR_W-1:0]   btb_targets,
    input  logic                       update_valid,
    input  logic [ADDR_W-1:0]          update_PC,
    input  logic [ADDR_W-1:0]          update_target,
    input  logic                       update_taken
`ifdef DEBUG
    ,
    output BTB_DEBUG                   btb_debug
`endif
);

    logic [N-1:0][IDX_BITS-1:0] fetchIdx;
    logic [N-1:0][TAG_BITS-1:0] fetchTag;
    logic [IDX_BITS-1:0]        updIdx;
    logic [TAG_BITS-1:0]        updTag;
    logic                       unusedPcBits;

    logic [N-1:0]               hit0;
    logic [N-1:0]               hit1;
    logic [N-1:0][ADDR_W-1:0]   tgt0;
    logic [N-1:0][ADDR_W-1:0]   tgt1;
    logic                       probeHit0;
    logic                       probeHit1;
    logic                       probeValid0;
    logic                       probeValid1;

    logic                       doUpdate;
    way_e                       victim;
    logic                       we0;
    logic                       we1;
    logic [BTB_SETS-1:0]        lru_q;
    logic [BTB_SETS-1:0]        lru_d;

    // Split every PC into set index and partial tag; the rest of the PC is deliberately ignored
    always_comb begin
        unusedPcBits = ^{update_PC[ADDR_W-1:TAG_HI+1], update_PC[1:0]};
        for (int i = 0; i < N; i++) begin
            fetchIdx[i]  = fetch_PCs[i][IDX_BITS+1:2];
            fetchTag[i]  = fetch_PCs[i][TAG_HI:IDX_BITS+2];
            unusedPcBits = unusedPcBits ^ (^{fetch_PCs[i][ADDR_W-1:TAG_HI+1], fetch_PCs[i][1:0]});
        end
    end

    assign updIdx = update_PC[IDX_BITS+1:2];
    assign updTag = update_PC[TAG_HI:IDX_BITS+2];

    btb_way u_way0 (
        .clock         (clock),
        .reset         (reset),
        .rd_idx_i      (fetchIdx),
        .rd_tag_i      (fetchTag),
        .rd_hit_o      (hit0),
        .rd_target_o   (tgt0),
        .probe_idx_i   (updIdx),
        .probe_tag_i   (updTag),
        .probe_hit_o   (probeHit0),
        .probe_valid_o (probeValid0),
        .we_i          (we0),
        .wr_idx_i      (updIdx),
        .wr_tag_i      (updTag),
        .wr_target_i   (update_target)
`ifdef DEBUG
        ,
        .dbg_valid_o   (btb_debug.way0_valid)
`endif
    );

    btb_way u_way1 (
        .clock         (clock),
        .reset         (reset),
        .rd_idx_i      (fetchIdx),
        .rd_tag_i      (fetchTag),
        .rd_hit_o      (hit1),
        .rd_target_o   (tgt1),
        .probe_idx_i   (updIdx),
        .probe_tag_i   (updTag),
        .probe_hit_o   (probeHit1),
        .probe_valid_o (probeValid1),
        .we_i          (we1),
        .wr_idx_i      (updIdx),
        .wr_tag_i      (updTag),
        .wr_target_i   (update_target)
`ifdef DEBUG
        ,
        .dbg_valid_o   (btb_debug.way1_valid)
`endif
    );

    // Merge the two ways per slot; way0 takes priority if both somehow match
    always_comb begin
        for (int i = 0; i < N; i++) begin
            btb_hits[i]    = 1'b0;
            btb_targets[i] = '0;
            if (fetch_valid[i] && hit0[i]) begin
                btb_hits[i]    = 1'b1;
                btb_targets[i] = tgt0[i];
            end else if (fetch_valid[i] && hit1[i]) begin
                btb_hits[i]    = 1'b1;
                btb_targets[i] = tgt1[i];
            end
        end
    end

    // Pick the way to write: refresh a matching way, else fill an empty one, else evict the LRU way
    always_comb begin
        doUpdate = update_valid && update_taken && !reset;
        victim   = WAY0;
        if (probeHit0) begin
            victim = WAY0;
        end else if (probeHit1) begin
            victim = WAY1;
        end else if (!probeValid0) begin
            victim = WAY0;
        end else if (!probeValid1) begin
            victim = WAY1;
        end else begin
            victim = way_e'(lru_q[updIdx]);
        end
        we0   = doUpdate && (victim == WAY0);
        we1   = doUpdate && (victim == WAY1);
        lru_d = lru_q;
        if (doUpdate) begin
            lru_d[updIdx] = (victim == WAY0);
        end
    end

    // LRU bits: the way just written becomes most recently used
    always_ff @(posedge clock) begin
        if (reset) begin
            lru_q <= '0;
        end else begin
            lru_q <= lru_d;
        end
    end

`ifdef DEBUG
    assign btb_debug.lru = lru_q;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for the branch target buffer: a driver issues lookups and
// updates and queues the expected lookup response; a monitor compares it.
module tb_branch_target_buffer;
    import branch_target_buffer_pkg::*;

    typedef logic [N-1:0][ADDR_W-1:0] pcvec_t;
    typedef struct packed {
        logic [N-1:0] hits;
        pcvec_t       tgts;
    } exp_t;
    typedef struct {
        int unsigned       tag;
        logic [ADDR_W-1:0] tgt;
    } ent_t;

    logic                clock;
    logic                reset;
    pcvec_t              fetchPCs;
    logic [N-1:0]        fetchValid;
    logic [N-1:0]        btbHits;
    pcvec_t              btbTargets;
    logic                updateValid;
    logic [ADDR_W-1:0]   updatePC;
    logic [ADDR_W-1:0]   updateTarget;
    logic                updateTaken;

    // Reference model: per set, a recency-ordered list of (tag, target), most recent first
    ent_t modelSets [BTB_SETS][$];
    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cycleNo = 0;

    branch_target_buffer dut (
        .clock         (clock),
        .reset         (reset),
        .fetch_PCs     (fetchPCs),
        .fetch_valid   (fetchValid),
        .btb_hits      (btbHits),
        .btb_targets   (btbTargets),
        .update_valid  (updateValid),
        .update_PC     (updatePC),
        .update_target (updateTarget),
        .update_taken  (updateTaken)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int unsigned setOf(logic [ADDR_W-1:0] pc);
        return (pc / 4) % BTB_SETS;
    endfunction

    function automatic int unsigned tagOf(logic [ADDR_W-1:0] pc);
        return (pc / (4 * BTB_SETS)) % (1 << TAG_BITS);
    endfunction

    function automatic exp_t modelLookup(pcvec_t pcs, logic [N-1:0] v);
        exp_t e;
        e = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                int unsigned s;
                s = setOf(pcs[i]);
                for (int k = 0; k < modelSets[s].size(); k++) begin
                    if (modelSets[s][k].tag == tagOf(pcs[i])) begin
                        e.hits[i] = 1'b1;
                        e.tgts[i] = modelSets[s][k].tgt;
                        break;
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic modelUpdate(input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] tgt);
        int unsigned s;
        ent_t        ne;
        s      = setOf(pc);
        ne.tag = tagOf(pc);
        ne.tgt = tgt;
        for (int k = 0; k < modelSets[s].size(); k++) begin
            if (modelSets[s][k].tag == ne.tag) begin
                modelSets[s].delete(k);
                break;
            end
        end
        modelSets[s].push_front(ne);
        if (modelSets[s].size() > 2) void'(modelSets[s].pop_back());
    endtask

    task automatic modelReset();
        for (int s = 0; s < BTB_SETS; s++) modelSets[s].delete();
    endtask

    function automatic exp_t mk(logic [N-1:0] h, pcvec_t t);
        exp_t e;
        e.hits = h;
        e.tgts = t;
        return e;
    endfunction

    // Drive one cycle of stimulus and queue the lookup response expected before the update lands
    task automatic applyStimulus(input pcvec_t pcs, input logic [N-1:0] v,
                                 input logic uv, input logic [ADDR_W-1:0] upc,
                                 input logic [ADDR_W-1:0] utgt, input logic utk,
                                 input logic rst, input logic useExplicit, input exp_t explicitExp);
        @(posedge clock);
        #1;
        reset        = rst;
        fetchPCs     = pcs;
        fetchValid   = v;
        updateValid  = uv;
        updatePC     = upc;
        updateTarget = utgt;
        updateTaken  = utk;
        cycleNo++;
        if (useExplicit) expQ.push_back(explicitExp);
        else             expQ.push_back(modelLookup(pcs, v));
        if (rst)              modelReset();
        else if (uv && utk)   modelUpdate(upc, utgt);
    endtask

    task automatic updateOnly(input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] tgt, input logic tk);
        applyStimulus('0, '0, 1'b1, pc, tgt, tk, 1'b0, 1'b1, '0);
    endtask

    task automatic lookupOnly(input pcvec_t pcs, input logic [N-1:0] v, input exp_t e);
        applyStimulus(pcs, v, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, e);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (btbHits !== e.hits) begin
            errors++;
            $display("[TB] FAIL hits cycle %0d: got %b want %b", cycleNo, btbHits, e.hits);
        end
        checks++;
        if (btbTargets !== e.tgts) begin
            errors++;
            $display("[TB] FAIL targets cycle %0d: got %h want %h", cycleNo, btbTargets, e.tgts);
        end
    endtask

    // Monitor: the lookup response is valid every cycle a stimulus was issued
    always @(negedge clock) begin
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    initial begin
        pcvec_t p;
        pcvec_t t;
        reset        = 1'b1;
        fetchPCs     = '0;
        fetchValid   = '0;
        updateValid  = 1'b0;
        updatePC     = '0;
        updateTarget = '0;
        updateTaken  = 1'b0;

        applyStimulus('0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, '0);
        applyStimulus('0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, '0);

        $display("[TB] empty after reset");
        for (int i = 0; i < N; i++) p[i] = $urandom;
        lookupOnly(p, '1, '0);

        $display("[TB] allocate 0x100 and same-cycle miss");
        p = '0; p[2] = 32'h100;
        applyStimulus(p, 4'b0100, 1'b1, 32'h100, 32'h240, 1'b1, 1'b0, 1'b1, '0);
        t = '0; t[2] = 32'h240;
        lookupOnly(p, 4'b0100, mk(4'b0100, t));

        $display("[TB] not-taken leaves entry, taken refreshes target");
        p = '0; p[0] = 32'h100;
        t = '0; t[0] = 32'h240;
        applyStimulus(p, 4'b0001, 1'b1, 32'h100, 32'h999, 1'b0, 1'b0, 1'b1, mk(4'b0001, t));
        lookupOnly(p, 4'b0001, mk(4'b0001, t));
        updateOnly(32'h100, 32'h300, 1'b1);
        t[0] = 32'h300;
        lookupOnly(p, 4'b0001, mk(4'b0001, t));
        updateOnly(32'h200, 32'h444, 1'b1);
        p[1] = 32'h200; t[1] = 32'h444;
        lookupOnly(p, 4'b0011, mk(4'b0011, t));

        $display("[TB] reset together with update");
        applyStimulus('0, '0, 1'b1, 32'h500, 32'h777, 1'b1, 1'b1, 1'b1, '0);
        p = '0; p[0] = 32'h500; p[1] = 32'h100; p[2] = 32'h200; p[3] = 32'h0;
        lookupOnly(p, '1, '0);

        $display("[TB] fill set 0 and evict LRU");
        updateOnly(32'h000, 32'h40, 1'b1);
        updateOnly(BTB_SETS * 4, 32'h80, 1'b1);
        updateOnly(2 * BTB_SETS * 4, 32'hC0, 1'b1);
        p = '0; p[0] = 32'h000; p[1] = BTB_SETS * 4; p[2] = 2 * BTB_SETS * 4;
        t = '0; t[1] = 32'h80; t[2] = 32'hC0;
        lookupOnly(p, 4'b0111, mk(4'b0110, t));

        $display("[TB] bundle with invalid slot and low PC bits");
        p = '0; p[0] = 32'h100; p[1] = 32'h100; p[2] = 32'h100; p[3] = 32'h103;
        t = '0; t[0] = 32'hC0; t[2] = 32'hC0; t[3] = 32'hC0;
        lookupOnly(p, 4'b1101, mk(4'b1101, t));

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            logic [ADDR_W-1:0] upc;
            logic [N-1:0]      v;
            for (int i = 0; i < N; i++) begin
                int unsigned sets[3];
                sets = '{0, 1, 5};
                p[i] = $urandom_range(0, 4) * (BTB_SETS * 4) + sets[$urandom_range(0, 2)] * 4
                       + $urandom_range(0, 3);
                if ($urandom_range(0, 15) == 0) p[i] = $urandom;
            end
            v   = N'($urandom);
            upc = $urandom_range(0, 4) * (BTB_SETS * 4) + ($urandom_range(0, 1) == 0 ? 0 : 4);
            applyStimulus(p, v, ($urandom_range(0, 1) == 1), upc, $urandom,
                          ($urandom_range(0, 9) < 7), ($urandom_range(0, 63) == 0), 1'b0, '0);
        end

        applyStimulus('0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0);
        @(posedge clock);
        @(negedge clock);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending want 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
